inst_mem_loader: RTL and testbench

Parametrised instruction memory with a streaming loader. It replaces the fixed 256-word instruction store: it adds a valid/ready load port with a length counter and a completion pulse. Fetch is registered and blocked while a load is in progress. The block sits between the fetch stage (PC in, instruction out) and the program loader or bench that streams the program image in.

---
 rtl/inst_mem_loader_if.sv | 36 +++
 rtl/inst_mem_loader.sv | 108 ++++++++++
 tb/tb_inst_mem_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: fetch port and streaming load port of the instruction memory.
`default_nettype none

interface inst_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256
);
  localparam int c_iw = $clog2(DEPTH);

  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] inst_out;
  logic                  inst_valid;
  logic                  load_start;
  logic [ADDR_WIDTH-1:0] load_base;
  logic [c_iw:0]         load_len;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_ready;
  logic                  load_busy;
  logic                  load_done;
  logic                  fault;

  modport master (
    output fetch_en, PC, load_start, load_base, load_len, load_data, load_valid,
    input  inst_out, inst_valid, load_ready, load_busy, load_done, fault
  );

  modport slave (
    input  fetch_en, PC, load_start, load_base, load_len, load_data, load_valid,
    output inst_out, inst_valid, load_ready, load_busy, load_done, fault
  );
endinterface

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
// Module      : inst_mem_loader
// Description : Instruction memory with registered fetch and a valid/ready
//               streaming loader (IDLE/LOAD/DONE). Optional fetch fault
//               detection is enabled by defining IMEM_FAULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h00000013)
) (
  input  wire logic        clk,
  input  wire logic        reset,
  inst_mem_loader_if.slave bus
);

  localparam int c_iw = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_iw-1:0]       r_ptr;
  logic [c_iw:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_inst_out;
  logic                  r_inst_valid;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_fetch_grant;
  logic                  w_load_accept;
  logic                  w_fetch_fault;
  logic [c_iw-1:0]       w_fetch_idx;

  // A same-cycle load_start takes priority over a fetch request.
  assign w_fetch_grant = (r_state == S_IDLE) && bus.fetch_en && !bus.load_start;
  assign w_load_accept = (r_state == S_LOAD) && bus.load_valid;
  assign w_fetch_idx   = bus.PC[c_iw+1:2];

`ifdef IMEM_FAULT_EN
  localparam logic [ADDR_WIDTH:0] c_byte_span = (ADDR_WIDTH+1)'(DEPTH) << 2;
  assign w_fetch_fault = (bus.PC[1:0] != 2'b00) || ({1'b0, bus.PC} >= c_byte_span);
`else
  assign w_fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_inst_out   <= NOP_WORD;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_inst_valid <= w_fetch_grant;
      r_fault      <= w_fetch_grant && w_fetch_fault;
      if (w_fetch_grant) begin
        r_inst_out <= w_fetch_fault ? NOP_WORD : r_mem[w_fetch_idx];
      end

      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_ptr   <= bus.load_base[c_iw+1:2];
            r_cnt   <= bus.load_len;
            r_state <= (bus.load_len == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.load_valid) begin
            r_ptr <= r_ptr + c_iw'(1);
            r_cnt <= r_cnt - (c_iw+1)'(1);
            if (r_cnt == (c_iw+1)'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_load_accept) begin
      r_mem[r_ptr] <= bus.load_data;
    end
  end

  assign bus.inst_out   = r_inst_out;
  assign bus.inst_valid = r_inst_valid;
  assign bus.fault      = r_fault;
  assign bus.load_ready = (r_state == S_LOAD);
  assign bus.load_busy  = (r_state == S_LOAD);
  assign bus.load_done  = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: randomized bench for inst_mem_loader against an array-based memory model.
`default_nettype none

module tb_inst_mem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk;
  logic reset;

  inst_mem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) bus ();

  inst_mem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH     (DEPTH),
    .NOP_WORD  (NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] last_inst;

  function automatic void exp_fetch(input logic [31:0] pc, output logic [31:0] w, output logic f);
`ifdef IMEM_FAULT_EN
    if (pc[1:0] != 2'b00 || pc >= 32'(DEPTH * 4)) begin
      w = NOP;
      f = 1'b1;
      return;
    end
`endif
    w = m_mem[(pc / 4) % DEPTH];
    f = 1'b0;
  endfunction

  task automatic do_fetch(input logic [31:0] pc, input string tag);
    logic [31:0] ew;
    logic        ef;
    exp_fetch(pc, ew, ef);
    bus.fetch_en = 1'b1;
    bus.PC       = pc;
    @(negedge clk);
    n_tests++;
    if (bus.inst_valid !== 1'b1 || bus.inst_out !== ew || bus.fault !== ef) begin
      n_fail++;
      $display("FAIL %s pc=%h: got valid=%b inst=%h fault=%b, want valid=1 inst=%h fault=%b",
               tag, pc, bus.inst_valid, bus.inst_out, bus.fault, ew, ef);
    end
    last_inst = ew;
  endtask

  task automatic check_idle_hold(input string tag);
    bus.fetch_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.inst_valid !== 1'b0 || bus.inst_out !== last_inst || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b inst=%h fault=%b, want valid=0 inst=%h fault=0",
               tag, bus.inst_valid, bus.inst_out, bus.fault, last_inst);
    end
  endtask

  // mode: 0 = valid held, 1 = valid toggling 1/0, 2 = random valid plus stray load_start
  task automatic run_load(input logic [31:0] base, input int len, input int mode,
                          input bit hold_fetch, input bit fixed, input logic [31:0] first,
                          input string tag);
    int          ptr;
    int          acc;
    int          cyc;
    bit          bad;
    bit          v;
    logic [31:0] d;
    ptr = int'((base >> 2) % DEPTH);
    acc = 0;
    cyc = 0;
    bad = 1'b0;
    bus.fetch_en   = hold_fetch;
    bus.load_start = 1'b1;
    bus.load_base  = base;
    bus.load_len   = 9'(len);
    @(negedge clk);
    bus.load_start = 1'b0;
    if (hold_fetch && bus.inst_valid !== 1'b0) bad = 1'b1;
    if (len == 0) begin
      n_tests++;
      if (bus.load_done !== 1'b1 || bus.load_busy !== 1'b0 || bad) begin
        n_fail++;
        $display("FAIL %s zero-len done: got done=%b busy=%b, want done=1 busy=0",
                 tag, bus.load_done, bus.load_busy);
      end
      @(negedge clk);
      n_tests++;
      if (bus.load_done !== 1'b0 || (hold_fetch && bus.inst_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL %s zero-len after: got done=%b valid=%b, want done=0 valid=0",
                 tag, bus.load_done, bus.inst_valid);
      end
      return;
    end
    n_tests++;
    if (bus.load_ready !== 1'b1 || bus.load_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s entry: got ready=%b busy=%b, want ready=1 busy=1",
               tag, bus.load_ready, bus.load_busy);
    end
    while (acc < len && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = fixed ? first + 32'(acc) : $urandom;
      bus.load_valid = v;
      bus.load_data  = d;
      bus.load_start = (mode == 2) && ($urandom_range(0, 3) == 0);
      bus.load_len   = 9'($urandom_range(0, DEPTH));
      bus.load_base  = $urandom;
      if (bus.load_ready !== 1'b1 || bus.load_done !== 1'b0) bad = 1'b1;
      if (hold_fetch && bus.inst_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
      if (v) begin
        m_mem[ptr]   = d;
        m_known[ptr] = 1'b1;
        ptr          = (ptr + 1) % DEPTH;
        acc++;
      end
      cyc++;
    end
    bus.load_valid = 1'b0;
    bus.load_start = 1'b0;
    n_tests++;
    if (acc != len || bad || (mode == 0 && cyc != len)) begin
      n_fail++;
      $display("FAIL %s stream: got accepted=%0d cycles=%0d protocol_err=%0b, want accepted=%0d protocol_err=0",
               tag, acc, cyc, bad, len);
    end
    n_tests++;
    if (bus.load_done !== 1'b1 || bus.load_ready !== 1'b0 ||
        (hold_fetch && bus.inst_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s done pulse: got done=%b ready=%b valid=%b, want done=1 ready=0 valid=0",
               tag, bus.load_done, bus.load_ready, bus.inst_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.load_done !== 1'b0 || bus.load_busy !== 1'b0 ||
        (hold_fetch && bus.inst_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL %s after done: got done=%b busy=%b valid=%b, want done=0 busy=0 valid=0",
               tag, bus.load_done, bus.load_busy, bus.inst_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.inst_out !== NOP || bus.inst_valid !== 1'b0 || bus.load_ready !== 1'b0 ||
        bus.load_busy !== 1'b0 || bus.load_done !== 1'b0 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got inst=%h valid=%b ready=%b busy=%b done=%b fault=%b, want %h 0 0 0 0 0",
               bus.inst_out, bus.inst_valid, bus.load_ready, bus.load_busy,
               bus.load_done, bus.fault, NOP);
    end
    last_inst = NOP;
  endtask

  task automatic test_load_basic;
    run_load(32'h0, 4, 0, 1'b0, 1'b1, 32'hA0, "basic_load");
    do_fetch(32'h0, "basic_f0");
    do_fetch(32'h4, "basic_f4");
    do_fetch(32'h8, "basic_f8");
    do_fetch(32'hC, "basic_f12");
    check_idle_hold("basic_hold");
  endtask

  task automatic test_wrap_stall;
    run_load(32'h3F8, 4, 1, 1'b0, 1'b0, 32'h0, "wrap_load");
    do_fetch(32'h3F8, "wrap_f254");
    do_fetch(32'h3FC, "wrap_f255");
    do_fetch(32'h000, "wrap_f0");
    do_fetch(32'h004, "wrap_f1");
    check_idle_hold("wrap_hold");
  endtask

  task automatic test_fetch_blocked;
    logic [31:0] ew;
    logic        ef;
    bus.PC = 32'h44;
    run_load(32'h40, 3, 2, 1'b1, 1'b0, 32'h0, "blocked_load");
    exp_fetch(32'h44, ew, ef);
    @(negedge clk);
    n_tests++;
    if (bus.inst_valid !== 1'b1 || bus.inst_out !== ew) begin
      n_fail++;
      $display("FAIL blocked_resume: got valid=%b inst=%h, want valid=1 inst=%h",
               bus.inst_valid, bus.inst_out, ew);
    end
    last_inst = ew;
    check_idle_hold("blocked_hold");
  endtask

  task automatic test_zero_len;
    run_load(32'h0, 0, 0, 1'b0, 1'b0, 32'h0, "zero_len");
    do_fetch(32'h0, "zero_len_nowrite");
    check_idle_hold("zero_len_hold");
  endtask

  task automatic test_reset_midload;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          done_seen;
    d0 = $urandom;
    d1 = $urandom;
    done_seen = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.load_start = 1'b1;
    bus.load_base  = 32'h0;
    bus.load_len   = 9'd4;
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = d0;
    @(negedge clk);
    bus.load_data  = d1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    m_mem[0] = d0;
    m_mem[1] = d1;
    m_known[0] = 1'b1;
    m_known[1] = 1'b1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.load_busy !== 1'b0 || bus.load_ready !== 1'b0 || bus.load_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_reset: got busy=%b ready=%b done=%b, want 0 0 0",
               bus.load_busy, bus.load_ready, bus.load_done);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.load_done !== 1'b0 || bus.load_busy !== 1'b0) done_seen = 1'b1;
    end
    n_tests++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL midload_no_done: got done/busy activity=1, want 0");
    end
    do_fetch(32'h0, "midload_f0");
    do_fetch(32'h4, "midload_f1");
    check_idle_hold("midload_hold");
  endtask

  task automatic test_fault;
    do_fetch(32'h2, "fault_misaligned");
    do_fetch(32'h400, "fault_range");
    do_fetch(32'h0, "fault_clear");
    check_idle_hold("fault_hold");
  endtask

  task automatic test_random;
    int          idx;
    int          tries;
    logic [31:0] pc;
    for (int r = 0; r < 6; r++) begin
      run_load($urandom, int'($urandom_range(0, 20)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), 1'b0, 32'h0, "rand_load");
      for (int k = 0; k < 8; k++) begin
        idx = int'($urandom_range(0, DEPTH - 1));
        tries = 0;
        while (!m_known[idx] && tries < 1000) begin
          idx = (idx + 1) % DEPTH;
          tries++;
        end
        pc = 32'(idx) * 4;
        if ($urandom_range(0, 3) == 0) pc = pc | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) pc = pc | (32'($urandom_range(1, 255)) << 10);
        do_fetch(pc, "rand_fetch");
      end
      check_idle_hold("rand_hold");
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.PC         = '0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_data  = '0;
    bus.load_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_wrap_stall();
    test_fetch_blocked();
    test_zero_len();
    test_reset_midload();
    test_fault();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
